// File: rtl/velocity_estimator.sv
// Velocity estimator: emits the signed position change across each window of
// accepted samples, with a single-entry output register and a sticky overrun flag.
module velocity_estimator #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int WINDOW_WIDTH     = 16
) (
  input  logic                        SYS_aclk,
  input  logic                        SYS_aresetn,
  input  logic [WINDOW_WIDTH-1:0]     FC_window_length,
  input  logic                        S_AXIS_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  output logic                        M_AXIS_tvalid,
  input  logic                        M_AXIS_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                        FC_overrun
);

  typedef enum logic {INIT, RUN} state_t;

  state_t                        state;
  logic [AXIS_TDATA_WIDTH-1:0]   reference;
  logic [WINDOW_WIDTH-1:0]       counter;
  logic [WINDOW_WIDTH-1:0]       active_window;
  logic [WINDOW_WIDTH-1:0]       window_sanitized;
  logic [WINDOW_WIDTH:0]         count_next;
  logic                          boundary;

  // A zero-length window would never complete, so it degrades to per-sample deltas.
  assign window_sanitized = (FC_window_length == '0) ? WINDOW_WIDTH'(1) : FC_window_length;
  assign count_next       = {1'b0, counter} + 1'b1;
  assign boundary         = S_AXIS_tvalid && (state == RUN) &&
                            (count_next == {1'b0, active_window});

  always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
    if (!SYS_aresetn) begin
      state         <= INIT;
      reference     <= '0;
      counter       <= '0;
      active_window <= '0;
      M_AXIS_tvalid <= 1'b0;
      M_AXIS_tdata  <= '0;
      FC_overrun    <= 1'b0;
    end else begin
      if (S_AXIS_tvalid) begin
        case (state)
          INIT: begin
            reference     <= S_AXIS_tdata;
            active_window <= window_sanitized;
            counter       <= '0;
            state         <= RUN;
          end
          RUN: begin
            if (boundary) begin
              reference     <= S_AXIS_tdata;
              active_window <= window_sanitized;
              counter       <= '0;
            end else begin
              counter <= count_next[WINDOW_WIDTH-1:0];
            end
          end
          default: state <= INIT;
        endcase
      end

      // A fresh result always wins the output register; losing an unaccepted one is flagged.
      if (boundary) begin
        M_AXIS_tdata  <= S_AXIS_tdata - reference;
        M_AXIS_tvalid <= 1'b1;
        if (M_AXIS_tvalid && !M_AXIS_tready)
          FC_overrun <= 1'b1;
      end else if (M_AXIS_tready) begin
        M_AXIS_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_velocity_estimator.sv
// Directed bench for velocity_estimator: a window-level behavioural model is
// checked every cycle, plus hand-computed literal expectations.
module tb_velocity_estimator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] window = 16'd1;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        ready = 1'b0;
  logic        dut_valid;
  logic [31:0] dut_data;
  logic        dut_overrun;

  int n_vec = 0;
  int n_err = 0;

  velocity_estimator #(.AXIS_TDATA_WIDTH(32), .WINDOW_WIDTH(16)) dut (
    .SYS_aclk         (clk),
    .SYS_aresetn      (rst_n),
    .FC_window_length (window),
    .S_AXIS_tvalid    (s_valid),
    .S_AXIS_tdata     (s_data),
    .M_AXIS_tvalid    (dut_valid),
    .M_AXIS_tready    (ready),
    .M_AXIS_tdata     (dut_data),
    .FC_overrun       (dut_overrun)
  );

  always #5 clk = ~clk;

  // Model: remembers the window's starting position and how many samples followed it.
  bit          m_seeded = 0;
  int          m_taken  = 0;
  int          m_win    = 1;
  logic [31:0] m_ref    = '0;
  bit          m_valid  = 0;
  logic [31:0] m_data   = '0;
  bit          m_ovr    = 0;

  always @(posedge clk or negedge rst_n) begin
    bit          produced;
    logic [31:0] delta;
    if (!rst_n) begin
      m_seeded = 0; m_taken = 0; m_win = 1; m_ref = '0;
      m_valid = 0; m_data = '0; m_ovr = 0;
    end else begin
      produced = 0;
      delta = '0;
      if (s_valid) begin
        if (!m_seeded) begin
          m_seeded = 1;
          m_ref    = s_data;
          m_taken  = 0;
          m_win    = (window == 0) ? 1 : int'(window);
        end else begin
          m_taken++;
          if (m_taken == m_win) begin
            produced = 1;
            delta    = s_data - m_ref;
            m_ref    = s_data;
            m_taken  = 0;
            m_win    = (window == 0) ? 1 : int'(window);
          end
        end
      end
      if (produced) begin
        if (m_valid && !ready) m_ovr = 1;
        m_valid = 1;
        m_data  = delta;
      end else if (ready) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      n_vec++;
      if (dut_valid !== m_valid) begin
        n_err++;
        $display("[TB] FAIL model_tvalid t=%0t got %b want %b", $time, dut_valid, m_valid);
      end
      n_vec++;
      if (dut_overrun !== m_ovr) begin
        n_err++;
        $display("[TB] FAIL model_overrun t=%0t got %b want %b", $time, dut_overrun, m_ovr);
      end
      if (m_valid) begin
        n_vec++;
        if (dut_data !== m_data) begin
          n_err++;
          $display("[TB] FAIL model_tdata t=%0t got %0d want %0d", $time,
                   $signed(dut_data), $signed(m_data));
        end
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r);
    @(negedge clk);
    s_valid = v;
    s_data  = d;
    ready   = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic v, input logic [31:0] d,
                             input logic o);
    n_vec++;
    if (dut_valid !== v || dut_data !== d || dut_overrun !== o) begin
      n_err++;
      $display("[TB] FAIL %s got valid=%b data=%0d ovr=%b want valid=%b data=%0d ovr=%b",
               name, dut_valid, $signed(dut_data), dut_overrun, v, $signed(d), o);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n   = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #12;
    checkOutput("reset_state", 1'b0, 32'd0, 1'b0);

    // Window 4, positions 0..8, always ready
    window = 16'd4;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i <= 4; i++) applyStimulus(1'b1, 32'(i), 1'b1);
    checkOutput("w4_first", 1'b1, 32'd4, 1'b0);
    applyStimulus(1'b1, 32'd5, 1'b1);
    checkOutput("w4_drop", 1'b0, 32'd4, 1'b0);
    for (int i = 6; i <= 8; i++) applyStimulus(1'b1, 32'(i), 1'b1);
    checkOutput("w4_second", 1'b1, 32'd4, 1'b0);
    applyStimulus(1'b0, 32'd99, 1'b1);

    // Window 3, decreasing positions
    doReset();
    window = 16'd3;
    applyStimulus(1'b1, 32'd10, 1'b1);
    applyStimulus(1'b1, 32'd5, 1'b1);
    applyStimulus(1'b1, 32'd0, 1'b1);
    applyStimulus(1'b1, -32'sd5, 1'b1);
    checkOutput("w3_first", 1'b1, -32'sd15, 1'b0);
    applyStimulus(1'b1, -32'sd10, 1'b1);
    applyStimulus(1'b1, -32'sd15, 1'b1);
    applyStimulus(1'b1, -32'sd20, 1'b1);
    checkOutput("w3_second", 1'b1, -32'sd15, 1'b0);

    // Window 0 acts as window 1; back-to-back results with ready high
    doReset();
    window = 16'd0;
    applyStimulus(1'b1, 32'd3, 1'b1);
    applyStimulus(1'b1, 32'd7, 1'b1);
    checkOutput("w0_first", 1'b1, 32'd4, 1'b0);
    applyStimulus(1'b1, 32'd6, 1'b1);
    checkOutput("w0_same_cycle", 1'b1, -32'sd1, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("w0_drop", 1'b0, -32'sd1, 1'b0);

    // Window 2 with back-pressure: overwrite sets overrun
    doReset();
    window = 16'd2;
    applyStimulus(1'b1, 32'd0, 1'b0);
    applyStimulus(1'b1, 32'd1, 1'b0);
    applyStimulus(1'b1, 32'd2, 1'b0);
    checkOutput("bp_first", 1'b1, 32'd2, 1'b0);
    applyStimulus(1'b1, 32'd3, 1'b0);
    checkOutput("bp_hold", 1'b1, 32'd2, 1'b0);
    applyStimulus(1'b1, 32'd5, 1'b0);
    checkOutput("bp_overwrite", 1'b1, 32'd3, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("bp_accept", 1'b0, 32'd3, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("bp_sticky", 1'b0, 32'd3, 1'b1);

    // Signed wrap-around
    doReset();
    window = 16'd2;
    applyStimulus(1'b1, 32'h7FFF_FFFE, 1'b1);
    applyStimulus(1'b1, 32'h7FFF_FFFF, 1'b1);
    applyStimulus(1'b1, 32'h8000_0000, 1'b1);
    checkOutput("wrap", 1'b1, 32'd2, 1'b0);

    // Window change mid-window takes effect at the next boundary
    doReset();
    window = 16'd4;
    applyStimulus(1'b1, 32'd0, 1'b1);
    applyStimulus(1'b1, 32'd1, 1'b1);
    window = 16'd2;
    applyStimulus(1'b1, 32'd2, 1'b1);
    applyStimulus(1'b1, 32'd3, 1'b1);
    checkOutput("wchg_mid", 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b1, 32'd4, 1'b1);
    checkOutput("wchg_first", 1'b1, 32'd4, 1'b0);
    applyStimulus(1'b1, 32'd10, 1'b1);
    checkOutput("wchg_gap", 1'b0, 32'd4, 1'b0);
    applyStimulus(1'b1, 32'd20, 1'b1);
    checkOutput("wchg_second", 1'b1, 32'd16, 1'b0);

    // Asynchronous reset mid-window with a pending result, then re-seed
    doReset();
    window = 16'd2;
    applyStimulus(1'b1, 32'd0, 1'b0);
    applyStimulus(1'b1, 32'd1, 1'b0);
    applyStimulus(1'b1, 32'd3, 1'b0);
    applyStimulus(1'b1, 32'd5, 1'b0);
    checkOutput("pre_reset", 1'b1, 32'd3, 1'b0);
    applyStimulus(1'b1, 32'd7, 1'b0);
    checkOutput("pre_reset_ovr", 1'b1, 32'd4, 1'b1);
    #2;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    #1;
    checkOutput("async_reset", 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    rst_n  = 1'b1;
    window = 16'd1;
    applyStimulus(1'b1, 32'd100, 1'b1);
    checkOutput("reseed_none", 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b1, 32'd104, 1'b1);
    checkOutput("reseed_delta", 1'b1, 32'd4, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
